// File: rtl/tdm_demux4.sv
// -----------------------------------------------------------------------------
// tdm_demux4 - four-lane time-division demultiplexer
//
// Takes a slot-interleaved stream (lane 0, 1, 2, 3, lane 0, ...) in which every
// lane-0 word carries a start-of-frame flag. The four words of a frame are
// collected and then presented together as one parallel frame under a
// valid/ready handshake.
//
// Optional feature macro: TDM_DEMUX_ERRCNT_EN
//   When defined, adds port err_cnt, a saturating count of sync_err pulses.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in         incoming slot word (WIDTH bits)
//   in_valid   in is valid this cycle
//   in_sof     in is the lane-0 word of a frame
//   in_ready   block can accept in this cycle (combinational)
//   out        frame, lane k at out[k*WIDTH +: WIDTH]
//   out_valid  out holds a complete frame
//   out_ready  consumer takes out this cycle
//   sync_err   one-cycle pulse on a framing violation
//   locked     high while in the COLLECT state
//   err_cnt    saturating sync-error count (TDM_DEMUX_ERRCNT_EN only)
// -----------------------------------------------------------------------------
module tdm_demux4 #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   in,
    input  logic               in_valid,
    input  logic               in_sof,
    output logic               in_ready,
    output logic [4*WIDTH-1:0] out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               sync_err,
`ifdef TDM_DEMUX_ERRCNT_EN
    output logic               locked,
    output logic [7:0]         err_cnt
`else
    output logic               locked
`endif
);

    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t                       state, state_n;
    logic [1:0]                   slot, slot_n;
    logic [3:0][WIDTH-1:0]        stage, stage_n;
    logic [4*WIDTH-1:0]           out_n;
    logic                         out_valid_n;
    logic                         sync_err_n;
    logic                         accept;

    // -------------------------------------------------------------------------
    // State register (all sequential state of the block)
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    // NOTE: the staging lanes are a handful of flops, not a RAM, so they are
    // cleared on reset like the rest of the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= HUNT;
            slot      <= 2'd0;
            stage     <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            state     <= state_n;
            slot      <= slot_n;
            stage     <= stage_n;
            out       <= out_n;
            out_valid <= out_valid_n;
            sync_err  <= sync_err_n;
        end
    end

`ifdef TDM_DEMUX_ERRCNT_EN
    // Counts on the same edge that raises sync_err; sticks at 255.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= 8'd0;
        end else if (sync_err_n && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    assign accept = in_valid & in_ready;

    // NOTE: every variable gets a default at the top of the block so that no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_n     = state;
        slot_n      = slot;
        stage_n     = stage;
        out_n       = out;
        out_valid_n = out_valid;
        sync_err_n  = 1'b0;

        // A held frame is released once the consumer takes it; a frame that
        // completes in the same cycle re-asserts out_valid below.
        if (out_valid && out_ready) begin
            out_valid_n = 1'b0;
        end

        if (accept) begin
            unique case (state)
                HUNT: begin
                    // Non-sof words are dropped while searching for a frame.
                    if (in_sof) begin
                        stage_n[0] = in;
                        slot_n     = 2'd1;
                        state_n    = COLLECT;
                    end
                end
                COLLECT: begin
                    if (in_sof) begin
                        // An early sof abandons the partial frame and restarts
                        // collection at lane 0.
                        sync_err_n = (slot != 2'd0);
                        stage_n[0] = in;
                        slot_n     = 2'd1;
                    end else begin
                        unique case (slot)
                            2'd0: begin
                                // Lane-0 word without sof: framing is lost.
                                sync_err_n = 1'b1;
                                state_n    = HUNT;
                            end
                            2'd1, 2'd2: begin
                                stage_n[slot] = in;
                                slot_n        = slot + 2'd1;
                            end
                            default: begin
                                stage_n[3]  = in;
                                out_n       = {in, stage[2], stage[1], stage[0]};
                                out_valid_n = 1'b1;
                                slot_n      = 2'd0;
                            end
                        endcase
                    end
                end
                default: begin
                    state_n = HUNT;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output logic
    // -------------------------------------------------------------------------
    // Only the word that would complete a new frame while the previous one is
    // still held stalls; lanes 0-2 keep flowing into staging meanwhile.
    always_comb begin
        locked   = (state == COLLECT);
        in_ready = ~(out_valid & ~out_ready & locked & (slot == 2'd3) & ~in_sof);
    end

endmodule
